// File: rtl/pos_mask_decoder.sv
// rtl/pos_mask_decoder.sv - accumulates bit-position codes into a multi-hot mask
//
// Purpose: inverse of the position encoder. Each accepted beat carries a bit
// position; the block ORs that bit into a registered mask. The frame's last
// beat moves the block to HOLD. In HOLD it presents the mask, the number of
// distinct bits set, and a sticky illegal-code flag until the consumer takes
// them.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   position beat valid
//   in_ready   block can accept a beat (high only in ACCUM)
//   in_pos     bit position, 0 = LSB; NONE_CODE = no bit; other codes >= DATA_W are illegal
//   in_last    final beat of the frame
//   out_valid  completed mask available (high only in HOLD)
//   out_ready  consumer takes the mask
//   out_data   accumulated mask
//   out_count  number of distinct bits set in out_data
//   out_err    frame contained an illegal code
//
// DATA_W must be no larger than 2**POS_W - 1.

module pos_mask_decoder #(
    parameter int DATA_W    = 32,
    parameter int POS_W     = 6,
    parameter int NONE_CODE = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [POS_W-1:0]  in_pos,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [POS_W-1:0]  out_count,
    output logic              out_err
);

    localparam int IDX_W = $clog2(DATA_W);

    localparam logic [POS_W-1:0]  DATA_W_CODE = POS_W'(DATA_W);
    localparam logic [POS_W-1:0]  NONE_P      = POS_W'(NONE_CODE);
    localparam logic [POS_W-1:0]  COUNT_ONE   = {{(POS_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] MASK_ONE    = {{(DATA_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   mask_q,  mask_d;
    logic [POS_W-1:0]    count_q, count_d;
    logic                err_q,   err_d;

    logic                accept;
    logic                in_range;
    logic [IDX_W-1:0]    bit_idx;
    logic [DATA_W-1:0]   bit_onehot;
    logic                bit_new;

    // Only the low index bits are meaningful when the code is in range.
    // Out-of-range codes never reach the mask because in_range gates them.
    assign in_range   = (in_pos < DATA_W_CODE);
    assign bit_idx    = in_pos[IDX_W-1:0];
    assign bit_onehot = MASK_ONE << bit_idx;
    // Counting only bits that are new makes duplicate positions idempotent.
    // The count therefore always equals popcount(mask) and cannot exceed DATA_W.
    assign bit_new    = ~|(mask_q & bit_onehot);
    assign accept     = in_valid && (state_q == ACCUM);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        count_d = count_q;
        err_d   = err_q;

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (in_range) begin
                        mask_d = mask_q | bit_onehot;
                        if (bit_new) begin
                            count_d = count_q + COUNT_ONE;
                        end
                    end else if (in_pos != NONE_P) begin
                        err_d = 1'b1;
                    end
                    if (in_last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // The transfer edge clears everything. There is no bypass to
                // accept a new beat in the same cycle.
                if (out_ready) begin
                    state_d = ACCUM;
                    mask_d  = '0;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            mask_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // The handshake flags decode directly from the state flop. The data
    // outputs are the accumulation registers themselves.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign out_data  = mask_q;
    assign out_count = count_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_pos_mask_decoder.sv
// tb/tb_pos_mask_decoder.sv - directed self-checking bench for pos_mask_decoder

`timescale 1ns/1ps

module tb_pos_mask_decoder;

    localparam int DATA_W    = 32;
    localparam int POS_W     = 6;
    localparam int NONE_CODE = 32;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [POS_W-1:0]  in_pos;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [POS_W-1:0]  out_count;
    logic              out_err;

    int n_chk  = 0;
    int n_fail = 0;

    pos_mask_decoder #(
        .DATA_W    (DATA_W),
        .POS_W     (POS_W),
        .NONE_CODE (NONE_CODE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pos    (in_pos),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference position encoder: index of the highest set bit, or NONE_CODE for zero.
    function automatic int encode(input logic [31:0] d);
        int p;
        p = NONE_CODE;
        for (int i = 0; i < 32; i++) begin
            if (d[i]) p = i;
        end
        return p;
    endfunction

    // Called at a negedge. Presents one beat after `gap` idle cycles, waits for
    // acceptance, and returns at the negedge that follows the accepting edge.
    task automatic send_beat(input int pos, input logic last, input int gap);
        logic ok;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_pos   = POS_W'(pos);
        in_last  = last;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    // Called at the negedge just after the last beat was accepted. Out_valid
    // must already be high, and the output must stay stable for `stall` cycles.
    task automatic recv_frame(input string tag, input logic [31:0] exp_data,
                              input int exp_count, input logic exp_err, input int stall);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"},  out_data,       exp_data);
        chk({tag, "_count"}, 32'(out_count), 32'(exp_count));
        chk({tag, "_err"},   32'(out_err),   32'(exp_err));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_data"},  out_data,       exp_data);
            chk({tag, "_hold_ready"}, 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_post_ready"}, 32'(in_ready),  32'd1);
        chk({tag, "_post_data"},  out_data,       32'd0);
    endtask

    int lb_pos [6] = '{0, 1, 16, 28, 29, 31};

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_pos    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  out_data,       32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_out_valid", 32'(out_valid), 32'd0);
            chk("idle_out_data",  out_data,       32'd0);
            chk("idle_in_ready",  32'(in_ready),  32'd1);
        end

        // Single MSB with 3 cycles of back-pressure
        send_beat(31, 1'b1, 0);
        recv_frame("msb", 32'h80000000, 1, 1'b0, 3);

        // Duplicate and NONE
        send_beat(0,  1'b0, 0);
        send_beat(28, 1'b0, 0);
        send_beat(32, 1'b0, 0);
        send_beat(28, 1'b0, 0);
        send_beat(15, 1'b1, 0);
        recv_frame("multi", 32'h10008001, 3, 1'b0, 0);

        // Illegal code, then a clean frame
        send_beat(1,  1'b0, 0);
        send_beat(40, 1'b0, 0);
        send_beat(29, 1'b1, 0);
        recv_frame("illegal", 32'h20000002, 2, 1'b1, 1);
        send_beat(0, 1'b1, 0);
        recv_frame("err_clr", 32'h00000001, 1, 1'b0, 0);

        // Full word with idle gaps between beats
        for (int p = 31; p >= 0; p--) begin
            send_beat(p, (p == 0), p % 3);
            if (p == 16) chk("full_mid_valid", 32'(out_valid), 32'd0);
        end
        // Present a beat during HOLD. It must not be accepted until after the transfer.
        in_valid = 1'b1;
        in_pos   = POS_W'(3);
        in_last  = 1'b1;
        for (int s = 0; s < 3; s++) begin
            chk("full_valid", 32'(out_valid), 32'd1);
            chk("full_data",  out_data,       32'hFFFFFFFF);
            chk("full_count", 32'(out_count), 32'd32);
            chk("full_err",   32'(out_err),   32'd0);
            chk("full_ready", 32'(in_ready),  32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("gap_valid", 32'(out_valid), 32'd0);
        chk("gap_ready", 32'(in_ready),  32'd1);
        chk("gap_data",  out_data,       32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        recv_frame("held_beat", 32'h00000008, 1, 1'b0, 0);

        // Reset mid-frame discards partial data
        send_beat(5, 1'b0, 0);
        send_beat(6, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_data",  out_data,       32'd0);
        chk("midrst_count", 32'(out_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_idle_valid", 32'(out_valid), 32'd0);
        send_beat(16, 1'b1, 0);
        recv_frame("after_rst", 32'h00010000, 1, 1'b0, 0);

        // Loopback through the reference encoder
        foreach (lb_pos[k]) begin
            send_beat(lb_pos[k], 1'b1, 0);
            chk("loop_pos", 32'(encode(out_data)), 32'(lb_pos[k]));
            recv_frame("loop", 32'h1 << lb_pos[k], 1, 1'b0, 0);
        end

        // Empty frame: NONE only
        send_beat(32, 1'b0, 0);
        send_beat(32, 1'b1, 0);
        chk("empty_enc", 32'(encode(out_data)), 32'd32);
        recv_frame("empty", 32'h0, 0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pos_mask_decoder.md
Name: pos_mask_decoder

Overview:
- Inverse of the team's 32-bit priority/position encoder.
- Accepts a stream of 6-bit bit-position codes over a valid/ready handshake and accumulates them into a 32-bit one-hot/multi-hot mask.
- Presents the completed mask, with a popcount and an error flag, on an output valid/ready handshake.
- Regenerates data words from position lists, and closes the loop with the encoder in self-checking benches.

Parameters:
- DATA_W, 32, output mask width. Must be ≤ 2^POS_W − 1.
- POS_W, 6, position code width.
- NONE_CODE, 32, position code meaning "no bit". Accepted as a no-op.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  position beat valid
- in_ready  output  1  block can accept a beat
- in_pos  input  POS_W  bit position; 0 = LSB, 31 = MSB
- in_last  input  1  final beat of the frame
- out_valid  output  1  completed mask available
- out_ready  input  1  consumer takes the mask
- out_data  output  DATA_W  accumulated mask
- out_count  output  POS_W  number of distinct bits set in out_data (0..32)
- out_err  output  1  frame contained an illegal code

Behaviour:
- Interface: one clock, clk; reset asynchronous active-low, rst_n.
- Reset state (async, immediate): state=ACCUM, mask=0, count=0, err=0.
- Reset output values: in_ready=1, out_valid=0, out_data=0, out_count=0, out_err=0.
- Reset mid-frame or mid-HOLD: discards all partial and pending data, with no output beat.
- States: ACCUM and HOLD.
- ACCUM:
  - in_ready=1, out_valid=0.
  - Beat accepted when in_valid & in_ready at the clock edge.
- Per accepted beat, by in_pos:
  - in_pos < DATA_W: set mask[in_pos]. Increment count only if that bit was previously 0, so duplicates are idempotent.
  - in_pos == NONE_CODE: no mask change, no error.
  - in_pos > DATA_W and ≠ NONE_CODE (33..63): mask unchanged; err set sticky for the frame.
- Accepted beat with in_last=1:
  - The beat's own bit is included.
  - Next state is HOLD.
- HOLD:
  - in_ready=0; out_valid=1.
  - out_data/out_count/out_err are registered and stable while out_valid=1 and out_ready=0.
- Latency: last beat accepted at edge N → out_valid=1 from edge N (visible cycle N+1).
- Output handshake: transfer when out_valid & out_ready at an edge. On that edge:
  - mask, count and err clear to 0;
  - state returns to ACCUM;
  - in_ready=1 in the following cycle. There is no same-cycle bypass; minimum gap is one cycle between frames.
- Zero-content frame (only NONE_CODE beats, or a single last beat with NONE_CODE): out_data=0, out_count=0, out_err=0.
- Full mask: all 32 distinct positions give out_data=32'hFFFFFFFF, out_count=32. No overflow is possible because the count saturates naturally at DATA_W.
- in_valid during HOLD: ignored, not accepted. The source must hold the beat (standard handshake).
- in_valid low for any number of cycles mid-frame: the accumulated state is held.
- Each output bit is a registered mask bit, not a combinational decode of in_pos. The mask update is pure OR; no bits are ever cleared within a frame.
- Out-of-frame data: none. Every accepted beat belongs to the current frame.

Test Plan:
- Reset values: reset asserted → out_valid=0, out_data=0, out_count=0, in_ready=1. Release, then idle for 5 cycles → outputs unchanged.
- Single MSB: beat pos=31, last=1 → next cycle out_valid=1, out_data=32'h80000000, out_count=1, out_err=0. Hold out_ready=0 for 3 cycles → output stable and in_ready=0. out_ready=1 → out_valid=0 and in_ready=1 on the following cycle.
- Multi-bit with duplicate and NONE: beats 0, 28, 32, 28, 15(last) → out_data=32'h10008001, out_count=3, out_err=0.
- Illegal code: beats 1, 40, 29(last) → out_data=32'h20000002, out_count=2, out_err=1. Next frame pos=0 last → out_data=32'h00000001, out_err=0 (err cleared).
- Full word with back-pressure: positions 31..0 with random in_valid gaps, last on 0 → out_data=32'hFFFFFFFF, out_count=32. Beats presented during HOLD are not accepted until after the output transfer.
- Reset mid-frame and round-trip:
  - Beats 5, 6, then assert rst_n=0 mid-frame → no out_valid. After release, frame pos=16(last) → out_data=32'h00010000.
  - Loopback: feed out_data of single-bit frames into the encoder → positions 0, 1, 16, 28, 29, 31 round-trip exactly.
  - Empty frame: NONE-only frame → 0 round-trips to encoder output 32.
